// File: rtl/key_event_decoder_if.sv
// Event output channel of key_event_decoder.
// The master drives event_valid/event_code/event_lost and samples event_ready.
// The slave is the event consumer.
interface key_event_decoder_if;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_ready;
    logic       event_lost;

    modport master (
        output event_valid,
        output event_code,
        input  event_ready,
        output event_lost
    );

    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready,
        input  event_lost
    );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies a debounced key into short / long / double
// click events using a 1 ms reference. Each event is held in a one-entry
// output slot until the consumer accepts it.
// Optional macro KEY_EVENT_REPEAT_EN adds auto-repeat events while a long
// press is held.
module key_event_decoder #(
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_ms,
    input  logic                 pressed,
    input  logic                 change,
    key_event_decoder_if.master  evt
);

    if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long
        $error("key_event_decoder: LONG_MS out of range 1..65535");
    end
    if (DOUBLE_MS < 1 || DOUBLE_MS > 65535) begin : g_bad_double
        $error("key_event_decoder: DOUBLE_MS out of range 1..65535");
    end
    if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat
        $error("key_event_decoder: REPEAT_MS out of range 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        EV_SHORT  = 2'b00,
        EV_LONG   = 2'b01,
        EV_DOUBLE = 2'b10,
        EV_REPEAT = 2'b11
    } code_t;

    localparam logic [16:0] LONG_C   = 17'(LONG_MS);
    localparam logic [16:0] DOUBLE_C = 17'(DOUBLE_MS);

    // clk_ms synchroniser and rising-edge detector
    logic ms_meta;
    logic ms_sync;
    logic ms_prev;
    logic tick;

    // key level as last reported by change, used to reject repeated strobes
    logic key_level;
    logic press_stb;
    logic rel_stb;
    logic any_stb;

    // state machine and ms counter
    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [16:0] cnt_inc;
    logic        cnt_clr;
    logic        hit_long;
    logic        hit_double;
    logic        ev_fire;
    code_t       ev_code;

    // output slot
    logic       slot_valid;
    logic [1:0] slot_code;
    logic       slot_lost;

    // Two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_meta <= 1'b0;
            ms_sync <= 1'b0;
            ms_prev <= 1'b0;
        end else begin
            ms_meta <= clk_ms;
            ms_sync <= ms_meta;
            ms_prev <= ms_sync;
        end
    end

    assign tick = ms_sync & ~ms_prev;

    // Track the debounced level so strobes that repeat it are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_level <= 1'b0;
        end else if (change) begin
            key_level <= pressed;
        end
    end

    // key_level resets to released, so a key held through reset needs a
    // fresh press strobe before anything happens.
    assign press_stb = change &  pressed & ~key_level;
    assign rel_stb   = change & ~pressed &  key_level;
    assign any_stb   = press_stb | rel_stb;

    assign cnt_inc    = {1'b0, cnt} + 17'd1;
    // A strobe in the same cycle discards the tick.
    assign hit_long   = tick & ~any_stb & (cnt_inc == LONG_C);
    assign hit_double = tick & ~any_stb & (cnt_inc == DOUBLE_C);

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [16:0] REPEAT_C = 17'(REPEAT_MS);
    logic hit_repeat;
    assign hit_repeat = tick & ~any_stb & (cnt_inc == REPEAT_C);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, event generation and counter-clear decode
    always_comb begin
        state_nx = state;
        ev_fire  = 1'b0;
        ev_code  = EV_SHORT;
        cnt_clr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (press_stb) begin
                    state_nx = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (rel_stb) begin
                    state_nx = ST_WAIT2;
                end else if (hit_long) begin
                    ev_fire  = 1'b1;
                    ev_code  = EV_LONG;
                    state_nx = ST_HELD;
                end
            end
            ST_WAIT2: begin
                if (press_stb) begin
                    state_nx = ST_PRESS2;
                end else if (hit_double) begin
                    ev_fire  = 1'b1;
                    ev_code  = EV_SHORT;
                    state_nx = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (rel_stb) begin
                    ev_fire  = 1'b1;
                    ev_code  = EV_DOUBLE;
                    state_nx = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (rel_stb) begin
                    state_nx = ST_IDLE;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (hit_repeat) begin
                    ev_fire = 1'b1;
                    ev_code = EV_REPEAT;
                    cnt_clr = 1'b1;
                end
`endif
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (state_nx != state) begin
            cnt_clr = 1'b1;
        end
    end

    // ms counter: cleared on state entry (and on repeat), counts surviving ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (tick && !any_stb) begin
            cnt <= cnt + 16'd1;
        end
    end

    // One-entry output slot: load when free or being accepted, else drop and flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_code  <= '0;
            slot_lost  <= 1'b0;
        end else if (ev_fire) begin
            if (!slot_valid || evt.event_ready) begin
                slot_valid <= 1'b1;
                slot_code  <= ev_code;
                slot_lost  <= 1'b0;
            end else begin
                slot_lost  <= 1'b1;
            end
        end else begin
            slot_lost <= 1'b0;
            if (evt.event_ready) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign evt.event_valid = slot_valid;
    assign evt.event_code  = slot_code;
    assign evt.event_lost  = slot_lost;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with default timing parameters.
// clk_ms is driven from clk negedges so tick timing is exact: the tick is
// high between the 2nd and 3rd rising clk edge after clk_ms rises, and an
// event becomes visible after the 3rd edge.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst;
    logic clk_ms;
    logic pressed;
    logic change;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    key_event_decoder_if evt();

    key_event_decoder #(
        .LONG_MS  (1000),
        .DOUBLE_MS(300),
        .REPEAT_MS(200)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_ms (clk_ms),
        .pressed(pressed),
        .change (change),
        .evt    (evt.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] c, input logic l);
        check({tag, "_valid"}, {1'b0, evt.event_valid}, {1'b0, v});
        check({tag, "_code"},  evt.event_code, c);
        check({tag, "_lost"},  {1'b0, evt.event_lost}, {1'b0, l});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {1'b0, evt.event_valid}, 2'b00);
        check({tag, "_lost"},  {1'b0, evt.event_lost}, 2'b00);
    endtask

    task automatic ms_periods(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            clk_ms = 1'b1;
            repeat (3) @(negedge clk);
            clk_ms = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // One ms period with exact checks around its tick; optionally asserts
    // event_ready and/or a change strobe in the tick cycle.
    task automatic ms_edge(input string tag, input logic pre_v,
                           input logic do_ready, input logic do_strobe, input logic slvl,
                           input logic exp_v, input logic [1:0] exp_c, input logic exp_l);
        clk_ms = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early"}, {1'b0, evt.event_valid}, {1'b0, pre_v});
        if (do_ready) evt.event_ready = 1'b1;
        if (do_strobe) begin
            pressed = slvl;
            change  = 1'b1;
        end
        @(negedge clk);
        evt.event_ready = 1'b0;
        change = 1'b0;
        check({tag, "_valid"}, {1'b0, evt.event_valid}, {1'b0, exp_v});
        check({tag, "_lost"},  {1'b0, evt.event_lost}, {1'b0, exp_l});
        if (exp_v) check({tag, "_code"}, evt.event_code, exp_c);
        clk_ms = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic strobe(input logic lvl);
        pressed = lvl;
        change  = 1'b1;
        @(negedge clk);
        change  = 1'b0;
    endtask

    task automatic accept(input string tag);
        evt.event_ready = 1'b1;
        @(negedge clk);
        evt.event_ready = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        rst = 1'b1;
        clk_ms = 1'b0;
        pressed = 1'b0;
        change = 1'b0;
        evt.event_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 2'b00, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // short: press, release after 100 ticks, short at 300th tick after release
        strobe(1'b1);
        check_idle("short_press");
        ms_periods(100);
        strobe(1'b0);
        check_idle("short_release");
        ms_periods(299);
        check_idle("short_299");
        ms_edge("short", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        ms_periods(5);
        check_out("short_hold", 1'b1, 2'b00, 1'b0);
        accept("short_acc");
        ms_periods(400);
        check_idle("short_once");

        // long: held 1000 ticks, then repeat (if built), release silent
        strobe(1'b1);
        ms_periods(999);
        check_idle("long_999");
        ms_edge("long", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        accept("long_acc");
`ifdef KEY_EVENT_REPEAT_EN
        ms_periods(199);
        check_idle("rep1_199");
        ms_edge("rep1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        accept("rep1_acc");
        ms_periods(199);
        check_idle("rep2_199");
        ms_edge("rep2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        accept("rep2_acc");
`else
        ms_periods(400);
        check_idle("no_repeat");
`endif
        strobe(1'b0);
        check_idle("long_release");
        ms_periods(350);
        check_idle("long_quiet");

        // release strobe coinciding with tick 1000: release wins, then short
        strobe(1'b1);
        ms_periods(999);
        ms_edge("tie", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        ms_periods(299);
        ms_edge("tie_short", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        accept("tie_acc");

        // double: press 50, release, re-press after 100, release
        strobe(1'b1);
        ms_periods(50);
        strobe(1'b0);
        check_idle("dbl_rel1");
        ms_periods(100);
        strobe(1'b1);
        check_idle("dbl_press2");
        strobe(1'b0);
        check_out("double", 1'b1, 2'b10, 1'b0);
        accept("dbl_acc");
        ms_periods(350);
        check_idle("dbl_no_short");

        // loss: second event while slot full, then load with simultaneous accept
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b0);
        check_out("lost_first", 1'b1, 2'b10, 1'b0);
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b0);
        check_out("lost_pulse", 1'b1, 2'b10, 1'b1);
        @(negedge clk);
        check_out("lost_once", 1'b1, 2'b10, 1'b0);
        strobe(1'b1);
        strobe(1'b0);
        ms_periods(299);
        ms_edge("swap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        accept("swap_acc");

        // reset in PRESS1 at tick 500 with a pending event
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b0);
        check_out("pend", 1'b1, 2'b10, 1'b0);
        strobe(1'b1);
        ms_periods(500);
        rst = 1'b1;
        @(negedge clk);
        check_out("mid_reset", 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        ms_periods(1050);
        check_idle("held_after_reset");
        strobe(1'b0);
        ms_periods(350);
        check_idle("stale_release");

        // fresh cycle; a repeated release strobe must not restart the window
        strobe(1'b1);
        ms_periods(10);
        strobe(1'b0);
        ms_periods(150);
        strobe(1'b0);
        ms_periods(149);
        check_idle("redund_299");
        ms_edge("fresh_short", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        accept("fresh_acc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
